fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, SHALL be the instruction word delivered with a misalignment fault.
REQ-002 Parameter BUF_DEPTH, default 2, SHALL be the output buffer depth in entries.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc  in  32  current fetch address from the program counter.
REQ-006 pc_ready  out  1  one-cycle pulse; the program counter SHALL advance only when high.
REQ-007 flush  in  1  redirect (taken branch/jump); discard all in-flight and buffered work.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  word-aligned request address.
REQ-010 imem_gnt  in  1  memory accepts the request this cycle.
REQ-011 imem_rvalid  in  1  read data valid, one per granted request, in order.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 if_valid  out  1  buffer head valid to decode.
REQ-014 if_instr  out  32  head instruction.
REQ-015 if_pc  out  32  head instruction's PC.
REQ-016 if_fault  out  1  head carries a misalignment fault.
REQ-017 if_ready  in  1  decode consumes head when if_valid is also high.

Function
REQ-018 FSM states IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-019 IDLE -> REQ when (buffer count + outstanding) < BUF_DEPTH and flush low; on entry, req_addr latches {pc[31:2],2'b00} and req_pc latches pc.
REQ-020 REQ: imem_req=1, imem_addr=req_addr, both stable until imem_gnt; on gnt -> WAIT, pc_ready=1 that cycle unless the request is marked flushed.
REQ-021 flush in REQ marks the request flushed; on its gnt -> DROP with pc_ready=0.
REQ-022 WAIT: on imem_rvalid push {req_pc, imem_rdata, fault=0}; next state REQ if room remains after the push, else IDLE.
REQ-023 flush in WAIT without rvalid -> DROP; flush with rvalid in the same cycle discards the data -> IDLE.
REQ-024 DROP: discard the next imem_rvalid, then -> IDLE; flush in DROP has no further effect.
REQ-025 pc[1:0] != 0 at IDLE->REQ decision: no memory request; push {pc, NOP_INSTR, fault=1}, pulse pc_ready, stay IDLE.
REQ-026 Buffer: FIFO of BUF_DEPTH entries, count 0..BUF_DEPTH; if_valid = (count != 0); pop on if_valid && if_ready.
REQ-027 Simultaneous push and pop when full: count unchanged, entry accepted; push is never offered when no slot is reserved.
REQ-028 flush empties the buffer: if_valid=0 next cycle; flush overrides push and pop in the same cycle.
REQ-029 Latency: rvalid in cycle N -> if_valid with that entry in cycle N+1; gnt to pc_ready is 0 cycles (combinational).
REQ-030 PC arithmetic is unchanged by this block; pc is consumed only as given, no increment here.

Reset
REQ-031 reset SHALL force state IDLE, buffer count 0, flushed mark 0, req_addr/req_pc 0.
REQ-032 During and after reset all outputs SHALL be 0 (imem_req, imem_addr, pc_ready, if_valid, if_instr, if_pc, if_fault).
REQ-033 reset SHALL override flush and any in-flight response; an imem_rvalid arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold the FSM state enumeration, NOP_INSTR default and the buffer entry record {pc, instr, fault}.
REQ-035 Buffer SHALL be a sub-module fetch_buffer (synchronous FIFO, push/pop/clear, count output); FSM and handshake logic in fetch_stage.

Verification
REQ-036 pc=0x100, gnt same cycle, rvalid 2 cycles later with 0x00500093, if_ready=1 -> pc_ready pulse at grant; if_valid=1, if_instr=0x00500093, if_pc=0x100 one cycle after rvalid.
REQ-037 if_ready=0, three fetches offered -> exactly 2 entries buffered, imem_req stays 0 until a pop, no data lost, order preserved.
REQ-038 flush in WAIT for pc=0x200, rvalid next cycle -> entry discarded, if_valid=0, pc_ready=0, next request uses new pc=0x400.
REQ-039 flush while imem_req=1 and gnt delayed 3 cycles -> address held stable, pc_ready=0 at gnt, response dropped.
REQ-040 pc=0x102 -> no imem_req; if_valid=1, if_fault=1, if_instr=0x00000013, if_pc=0x102, one pc_ready pulse.
REQ-041 reset asserted in WAIT with rvalid arriving next cycle -> all outputs 0, response ignored, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state codes, default NOP and the buffer entry record.
// No logic; imported by fetch_buffer and fetch_stage.
// Backpressure: n/a.
package fetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DROP = 2'd3;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched entries for decode, with clear and occupancy count.
// Latency: push in cycle N is visible at the head in cycle N+1.
// Backpressure: push is accepted when not full or when a pop happens in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Clear shares the reset path so a flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, responses buffered for decode; misaligned PCs yield a faulting NOP.
// Latency: rvalid in cycle N gives if_valid in N+1; pc_ready is combinational with imem_gnt.
// Backpressure: a request is only issued when a buffer slot is reserved for its response.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault,
    input  logic        if_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUF_DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             flushed;
    logic [31:0]      req_addr;
    logic [31:0]      req_pc;

    logic [CNT_W-1:0] buf_count;
    fetch_entry_t     buf_head;
    fetch_entry_t     push_entry;
    logic             push;
    logic             pop;
    logic             buf_valid;
    logic             has_room;
    logic             room_after;
    logic             misaligned;
    logic             latch_pc;
    logic             pc_ready_int;

    assign buf_valid  = (buf_count != '0);
    assign pop        = buf_valid && if_ready;
    // Outside IDLE a slot is already reserved, so only the buffer count gates a new fetch here.
    assign has_room   = (buf_count < FULL_CNT);
    assign room_after = pop || (buf_count < LAST_CNT);
    assign misaligned = (pc[1:0] != 2'b00);

    always_comb begin
        state_nxt        = state;
        push             = 1'b0;
        push_entry.pc    = req_pc;
        push_entry.instr = imem_rdata;
        push_entry.fault = 1'b0;
        latch_pc         = 1'b0;
        pc_ready_int     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!flush && has_room) begin
                    if (misaligned) begin
                        push             = 1'b1;
                        push_entry.pc    = pc;
                        push_entry.instr = NOP_INSTR;
                        push_entry.fault = 1'b1;
                        pc_ready_int     = 1'b1;
                    end else begin
                        state_nxt = ST_REQ;
                        latch_pc  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    if (flushed || flush) begin
                        state_nxt = ST_DROP;
                    end else begin
                        state_nxt    = ST_WAIT;
                        pc_ready_int = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    push = 1'b1;
                    // A misaligned next PC goes back through IDLE to produce its fault entry.
                    if (room_after && !misaligned) begin
                        state_nxt = ST_REQ;
                        latch_pc  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            flushed  <= 1'b0;
            req_addr <= '0;
            req_pc   <= '0;
        end else begin
            state   <= state_nxt;
            flushed <= (state == ST_REQ) && !imem_gnt && (flushed || flush);
            if (latch_pc) begin
                req_addr <= align_word(pc);
                req_pc   <= pc;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (buf_head),
        .count      (buf_count)
    );

    assign imem_req  = !reset && (state == ST_REQ);
    assign imem_addr = imem_req ? req_addr : '0;
    assign pc_ready  = !reset && pc_ready_int;
    assign if_valid  = !reset && buf_valid;
    assign if_instr  = if_valid ? buf_head.instr : '0;
    assign if_pc     = if_valid ? buf_head.pc    : '0;
    assign if_fault  = if_valid && buf_head.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs driven on the falling edge, outputs checked 1ns later.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;
    logic        if_ready;

    int tests;
    int fails;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_fault    (if_fault),
        .if_ready    (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},    32'(imem_req),  32'h0);
        chk({tag, "_addr"},   imem_addr,      32'h0);
        chk({tag, "_pcrdy"},  32'(pc_ready),  32'h0);
        chk({tag, "_valid"},  32'(if_valid),  32'h0);
        chk({tag, "_instr"},  if_instr,       32'h0);
        chk({tag, "_ifpc"},   if_pc,          32'h0);
        chk({tag, "_fault"},  32'(if_fault),  32'h0);
    endtask

    // Returns at a falling edge with reset just released and the DUT in IDLE.
    task automatic do_reset();
        nx();
        reset       = 1'b1;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;
        pc          = '0;
        nx();
        nx();
        reset = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        pc          = 32'h100;
        flush       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if_ready    = 1'b0;

        // Outputs held at zero while reset is asserted
        nx(); #1;
        chk_all_zero("rst");

        // Basic fetch at 0x100
        do_reset();
        pc = 32'h100; if_ready = 1'b1;
        #1 chk("t1_idle_req", 32'(imem_req), 32'h0);
        nx(); imem_gnt = 1'b1;
        #1 chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, 32'h100);
        chk("t1_pcrdy_gnt", 32'(pc_ready), 32'h1);
        nx(); imem_gnt = 1'b0; pc = 32'h104;
        #1 chk("t1_pcrdy_wait", 32'(pc_ready), 32'h0);
        chk("t1_nvalid_wait", 32'(if_valid), 32'h0);
        nx(); imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1 chk("t1_nvalid_rv", 32'(if_valid), 32'h0);
        nx(); imem_rvalid = 1'b0;
        #1 chk("t1_valid", 32'(if_valid), 32'h1);
        chk("t1_instr", if_instr, 32'h0050_0093);
        chk("t1_ifpc", if_pc, 32'h100);
        chk("t1_fault", 32'(if_fault), 32'h0);
        chk("t1_next_addr", imem_addr, 32'h104);

        // Buffer fills with decode stalled; order preserved
        do_reset();
        pc = 32'h200;
        nx(); imem_gnt = 1'b1;
        #1 chk("t2_addr0", imem_addr, 32'h200);
        nx(); imem_gnt = 1'b0; pc = 32'h204;
        nx(); imem_rvalid = 1'b1; imem_rdata = 32'hA1A1_0001;
        nx(); imem_rvalid = 1'b0; imem_gnt = 1'b1;
        #1 chk("t2_addr1", imem_addr, 32'h204);
        chk("t2_pcrdy1", 32'(pc_ready), 32'h1);
        chk("t2_head_a", if_instr, 32'hA1A1_0001);
        nx(); imem_gnt = 1'b0; pc = 32'h208; imem_rvalid = 1'b1; imem_rdata = 32'hA2A2_0002;
        nx(); imem_rvalid = 1'b0;
        #1 chk("t2_full_noreq", 32'(imem_req), 32'h0);
        nx(); if_ready = 1'b1;
        #1 chk("t2_full_noreq2", 32'(imem_req), 32'h0);
        chk("t2_head_b", if_instr, 32'hA1A1_0001);
        chk("t2_headpc_b", if_pc, 32'h200);
        nx(); if_ready = 1'b0;
        #1 chk("t2_noreq_pop", 32'(imem_req), 32'h0);
        chk("t2_head_c", if_instr, 32'hA2A2_0002);
        chk("t2_headpc_c", if_pc, 32'h204);
        nx();
        #1 chk("t2_req_after_pop", 32'(imem_req), 32'h1);
        chk("t2_addr2", imem_addr, 32'h208);
        imem_gnt = 1'b1;
        nx(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA3A3_0003; pc = 32'h20C;
        nx(); imem_rvalid = 1'b0; if_ready = 1'b1;
        #1 chk("t2_head_d", if_instr, 32'hA2A2_0002);
        nx();
        #1 chk("t2_head_e", if_instr, 32'hA3A3_0003);
        chk("t2_headpc_e", if_pc, 32'h208);
        nx();
        #1 chk("t2_empty", 32'(if_valid), 32'h0);

        // Flush in WAIT, response arrives a cycle later and is dropped
        do_reset();
        pc = 32'h200; if_ready = 1'b1;
        nx(); imem_gnt = 1'b1;
        #1 chk("t3_pcrdy_gnt", 32'(pc_ready), 32'h1);
        nx(); imem_gnt = 1'b0; flush = 1'b1; pc = 32'h400;
        #1 chk("t3_pcrdy_flush", 32'(pc_ready), 32'h0);
        nx(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1 chk("t3_drop_noreq", 32'(imem_req), 32'h0);
        chk("t3_drop_pcrdy", 32'(pc_ready), 32'h0);
        nx(); imem_rvalid = 1'b0;
        #1 chk("t3_discarded", 32'(if_valid), 32'h0);
        nx();
        #1 chk("t3_new_req", 32'(imem_req), 32'h1);
        chk("t3_new_addr", imem_addr, 32'h400);
        chk("t3_still_empty", 32'(if_valid), 32'h0);

        // Flush coinciding with rvalid in WAIT discards data and returns to IDLE
        do_reset();
        pc = 32'h700; if_ready = 1'b1;
        nx(); imem_gnt = 1'b1;
        nx(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; flush = 1'b1; pc = 32'h800;
        nx(); imem_rvalid = 1'b0; flush = 1'b0;
        #1 chk("t3b_discarded", 32'(if_valid), 32'h0);
        chk("t3b_idle", 32'(imem_req), 32'h0);
        nx();
        #1 chk("t3b_new_addr", imem_addr, 32'h800);

        // Flush during REQ with grant delayed three cycles
        do_reset();
        pc = 32'h300; if_ready = 1'b1;
        nx();
        #1 chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr0", imem_addr, 32'h300);
        flush = 1'b1; pc = 32'h500;
        nx(); flush = 1'b0;
        #1 chk("t4_addr1", imem_addr, 32'h300);
        chk("t4_req1", 32'(imem_req), 32'h1);
        nx(); imem_gnt = 1'b1;
        #1 chk("t4_addr2", imem_addr, 32'h300);
        chk("t4_pcrdy_gnt", 32'(pc_ready), 32'h0);
        nx(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1 chk("t4_drop_noreq", 32'(imem_req), 32'h0);
        nx(); imem_rvalid = 1'b0;
        #1 chk("t4_dropped", 32'(if_valid), 32'h0);
        nx();
        #1 chk("t4_new_addr", imem_addr, 32'h500);

        // Misaligned PC produces a faulting NOP without a memory request
        do_reset();
        pc = 32'h102;
        #1 chk("t5_pcrdy", 32'(pc_ready), 32'h1);
        chk("t5_noreq", 32'(imem_req), 32'h0);
        nx(); pc = 32'h106;
        #1 chk("t5_valid", 32'(if_valid), 32'h1);
        chk("t5_fault", 32'(if_fault), 32'h1);
        chk("t5_instr", if_instr, 32'h0000_0013);
        chk("t5_ifpc", if_pc, 32'h102);
        chk("t5_noreq2", 32'(imem_req), 32'h0);
        nx();
        #1 chk("t5_full_pcrdy", 32'(pc_ready), 32'h0);
        chk("t5_head_hold", if_pc, 32'h102);
        if_ready = 1'b1;
        nx();
        #1 chk("t5_second_pc", if_pc, 32'h106);
        chk("t5_second_fault", 32'(if_fault), 32'h1);

        // Reset in WAIT; response in the first cycle after reset is ignored
        do_reset();
        pc = 32'h600; if_ready = 1'b1;
        nx(); imem_gnt = 1'b1;
        nx(); imem_gnt = 1'b0; reset = 1'b1;
        #1 chk_all_zero("t6_rst");
        nx(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        #1 chk("t6_noreq", 32'(imem_req), 32'h0);
        chk("t6_pcrdy", 32'(pc_ready), 32'h0);
        chk("t6_nvalid", 32'(if_valid), 32'h0);
        nx(); imem_rvalid = 1'b0;
        #1 chk("t6_ignored", 32'(if_valid), 32'h0);
        chk("t6_idle_req", 32'(imem_req), 32'h1);
        chk("t6_addr", imem_addr, 32'h600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
